// File: rtl/frame_wr_master_pkg.sv
// Shared types and limits for the frame write master: FSM encoding and
// burst/FIFO sizing bounds used to size internal counters.
package frame_wr_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } fsm_state_e;

    localparam int BURST_LEN_MIN  = 2;
    localparam int BURST_LEN_MAX  = 16;
    localparam int FIFO_DEPTH_DEF = 64;
    localparam int ADDR_INC_DEF   = 512;

endpackage

// File: rtl/frame_wr_master_if.sv
// Write address + write data channel bundle between the frame master and
// the interconnect slave port. W has no valid: data is live while in W phase.
interface frame_wr_master_if #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     m_AWID;
    logic [ADDR_WIDTH-1:0]   m_AWADDR;
    logic [7:0]              m_AWLEN;
    logic                    m_AWVALID;
    logic                    m_AWREADY;
    logic [DATA_WIDTH-1:0]   m_WDATA;
    logic [DATA_WIDTH/8-1:0] m_WSTRB;
    logic                    m_WLAST;
    logic                    m_WREADY;

    modport master (
        output m_AWID, m_AWADDR, m_AWLEN, m_AWVALID,
        output m_WDATA, m_WSTRB, m_WLAST,
        input  m_AWREADY, m_WREADY
    );

    modport slave (
        input  m_AWID, m_AWADDR, m_AWLEN, m_AWVALID,
        input  m_WDATA, m_WSTRB, m_WLAST,
        output m_AWREADY, m_WREADY
    );
endinterface

// File: rtl/frame_wr_master_sync_fifo.sv
// Show-ahead synchronous FIFO: rd_data_o always shows the head entry, a pop
// exposes the next one on the following cycle. Flush wins over push/pop.
module sync_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   wr_en_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   rd_en_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    assign push = wr_en_i && !full_o && !flush_i;
    assign pop  = rd_en_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/frame_wr_master.sv
// Streams incoming beats into fixed-length write bursts at a frame-relative
// address that steps per burst and wraps once the frame is complete.
module frame_wr_master
    import frame_wr_master_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 256,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    ID_WIDTH     = 4,
    parameter int                    MASTER_ID    = 0,
    parameter int                    BURST_LEN    = 16,
    parameter int                    FIFO_DEPTH   = FIFO_DEPTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] FRAME_BASE   = '0,
    parameter int                    FRAME_BURSTS = 1024,
    parameter int                    ADDR_INC     = ADDR_INC_DEF
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic                          frame_start,
    input  logic                          in_valid,
    input  logic [DATA_WIDTH-1:0]         in_data,
    frame_wr_master_if.master             m,
    output logic                          axi_wstart_locked,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(BURST_LEN_MAX);

    fsm_state_e            state_q, state_d;
    logic                  awvalid_q, awvalid_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [7:0]            awlen_q, awlen_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           burst_cnt_q, burst_cnt_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic                  pending_q, pending_d;
    logic                  overflow_q, overflow_d;
    logic                  flush, pop, fifo_full, fifo_empty, last_beat;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (ACLK),
        .rst_n     (ARESETn),
        .flush_i   (flush),
        .wr_en_i   (in_valid),
        .wr_data_i (in_data),
        .rd_en_i   (pop),
        .rd_data_o (m.m_WDATA),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_level)
    );

    assign last_beat         = (state_q == ST_DATA) && (beat_q == BW'(BURST_LEN - 1));
    assign m.m_AWID          = ID_WIDTH'(MASTER_ID);
    assign m.m_AWADDR        = awaddr_q;
    assign m.m_AWLEN         = awlen_q;
    assign m.m_AWVALID       = awvalid_q;
    assign m.m_WSTRB         = '1;
    assign m.m_WLAST         = last_beat;
    assign axi_wstart_locked = (state_q != ST_IDLE);
    assign overflow          = overflow_q;

    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        awaddr_d    = awaddr_q;
        awlen_d     = awlen_q;
        addr_d      = addr_q;
        burst_cnt_d = burst_cnt_q;
        beat_d      = beat_q;
        pending_d   = pending_q;
        overflow_d  = overflow_q;
        flush       = 1'b0;
        pop         = 1'b0;

        if (in_valid && fifo_full) overflow_d = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                // A deferred restart is serviced alone; the next burst waits a cycle.
                if (pending_q || frame_start) begin
                    flush       = 1'b1;
                    addr_d      = FRAME_BASE;
                    burst_cnt_d = '0;
                    overflow_d  = 1'b0;
                    pending_d   = 1'b0;
                end else if (fifo_level >= LW'(BURST_LEN)) begin
                    state_d   = ST_ADDR;
                    awvalid_d = 1'b1;
                    awaddr_d  = addr_q;
                    awlen_d   = 8'(BURST_LEN - 1);
                end
            end
            ST_ADDR: begin
                if (frame_start) pending_d = 1'b1;
                if (m.m_AWREADY) begin
                    awvalid_d = 1'b0;
                    beat_d    = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (frame_start) pending_d = 1'b1;
                pop = m.m_WREADY && !fifo_empty;
                if (pop) begin
                    if (last_beat) begin
                        state_d = ST_IDLE;
                        beat_d  = '0;
                        if (burst_cnt_q == 32'(FRAME_BURSTS - 1)) begin
                            addr_d      = FRAME_BASE;
                            burst_cnt_d = '0;
                        end else begin
                            addr_d      = addr_q + ADDR_WIDTH'(ADDR_INC);
                            burst_cnt_d = burst_cnt_q + 32'd1;
                        end
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= ST_IDLE;
            awvalid_q   <= 1'b0;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            addr_q      <= FRAME_BASE;
            burst_cnt_q <= '0;
            beat_q      <= '0;
            pending_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            awaddr_q    <= awaddr_d;
            awlen_q     <= awlen_d;
            addr_q      <= addr_d;
            burst_cnt_q <= burst_cnt_d;
            beat_q      <= beat_d;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_frame_wr_master.sv
// Directed bench for frame_wr_master: a cycle table for the basic burst, then
// hand-written sequences for stalls, wrap, overflow, restart and reset.
module tb_frame_wr_master;
    localparam int DW = 256;
    localparam int AW = 32;
    localparam int LW = 7;
    localparam int BL = 16;

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b1;
    logic          frame_start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          axi_wstart_locked, overflow;
    logic [LW-1:0] fifo_level;

    frame_wr_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(4)) bus ();

    frame_wr_master #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(4), .MASTER_ID(5),
        .BURST_LEN(BL), .FIFO_DEPTH(64), .FRAME_BASE('0), .FRAME_BURSTS(3), .ADDR_INC(512)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .frame_start(frame_start),
        .in_valid(in_valid), .in_data(in_data), .m(bus),
        .axi_wstart_locked(axi_wstart_locked), .overflow(overflow), .fifo_level(fifo_level)
    );

    always #5 ACLK = ~ACLK;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct packed { logic last; logic [DW-1:0] data; } beat_t;
    beat_t         w_q[$];
    logic [AW-1:0] aw_q[$];

    task automatic chk(input string name, input logic [DW:0] act, input logic [DW:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h (top %0b) expected %0h (top %0b)",
                     name, act[63:0], act[DW], exp[63:0], exp[DW]);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [31:0] v);
        return {8{v}};
    endfunction

    function automatic beat_t beat_at(input int i);
        if (i < w_q.size()) return w_q[i];
        return 'x;
    endfunction

    function automatic logic [AW-1:0] aw_at(input int i);
        if (i < aw_q.size()) return aw_q[i];
        return 'x;
    endfunction

    // Passive monitor: logs handshakes and checks hold-while-stalled behaviour.
    logic          m_inw, p_awv, p_awr, p_inw, p_wr;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata;
    initial begin p_awv = 0; p_awr = 0; p_inw = 0; p_wr = 0; p_addr = '0; p_wdata = '0; end

    always @(negedge ACLK) begin
        if (!ARESETn) begin
            p_awv = 0; p_inw = 0;
        end else begin
            m_inw = axi_wstart_locked && !bus.m_AWVALID;
            if (p_awv && !p_awr) chk("aw_hold", {bus.m_AWVALID, bus.m_AWADDR}, {1'b1, p_addr});
            if (p_inw && !p_wr && m_inw) chk("w_hold", bus.m_WDATA, p_wdata);
            if (bus.m_WLAST) chk("wlast_in_w", m_inw, 1);
            if (bus.m_AWVALID && bus.m_AWREADY) aw_q.push_back(bus.m_AWADDR);
            if (m_inw && bus.m_WREADY) w_q.push_back({bus.m_WLAST, bus.m_WDATA});
            p_awv = bus.m_AWVALID; p_awr = bus.m_AWREADY; p_addr = bus.m_AWADDR;
            p_inw = m_inw; p_wr = bus.m_WREADY; p_wdata = bus.m_WDATA;
        end
    end

    task automatic tick();
        @(posedge ACLK); #1;
    endtask

    task automatic push(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1; in_data = mk(base + 32'(i)); tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        ARESETn = 1'b0; frame_start = 0; in_valid = 0;
        bus.m_AWREADY = 0; bus.m_WREADY = 0;
        repeat (2) tick();
        ARESETn = 1'b1; tick();
        aw_q.delete(); w_q.delete();
    endtask

    task automatic wait_idle(input string name, input int max);
        bit ok = 0;
        for (int i = 0; i < max && !ok; i++) begin
            tick();
            ok = !axi_wstart_locked && !bus.m_AWVALID && (fifo_level < 7'(BL));
        end
        tick();
        chk({name, "_idle"}, ok, 1);
    endtask

    task automatic chk_beats(input string name, input int n, input logic [31:0] base);
        beat_t e;
        chk({name, "_count"}, w_q.size(), n);
        for (int i = 0; i < n; i++) begin
            e.last = ((i % BL) == BL - 1);
            e.data = mk(base + 32'(i));
            chk($sformatf("%s[%0d]", name, i), beat_at(i), e);
        end
    endtask

    task automatic wait_w(input string name, output bit found);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge ACLK);
            found = axi_wstart_locked && !bus.m_AWVALID;
            if (!found) tick();
        end
        chk({name, "_in_w"}, found, 1);
    endtask

    typedef struct {
        logic          awr, wr;
        logic          e_awv, e_lock, e_last, e_inw;
        logic [31:0]   e_data;
        logic [LW-1:0] e_lvl;
    } vec_t;
    vec_t vt[19];

    initial begin : main
        bit found;
        vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 7'd16};
        vt[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 7'd16};
        for (int k = 0; k < 16; k++)
            vt[2+k] = '{1'b1, 1'b1, 1'b0, 1'b1, (k == 15), 1'b1, 32'(k + 1), 7'(16 - k)};
        vt[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 7'd0};

        // Asynchronous reset with no clock edge in between.
        #2 ARESETn = 1'b0; bus.m_AWREADY = 0; bus.m_WREADY = 0;
        #1;
        chk("rst_awvalid", bus.m_AWVALID, 0);
        chk("rst_wlast", bus.m_WLAST, 0);
        chk("rst_lock", axi_wstart_locked, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_awaddr", bus.m_AWADDR, 0);
        chk("rst_awlen", bus.m_AWLEN, 0);
        do_reset();

        // Single burst, cycle by cycle.
        bus.m_AWREADY = 1; bus.m_WREADY = 1;
        push(16, 32'h1);
        for (int i = 0; i < 19; i++) begin
            bus.m_AWREADY = vt[i].awr; bus.m_WREADY = vt[i].wr;
            @(negedge ACLK);
            chk($sformatf("v%0d_awvalid", i), bus.m_AWVALID, vt[i].e_awv);
            chk($sformatf("v%0d_lock", i), axi_wstart_locked, vt[i].e_lock);
            chk($sformatf("v%0d_wlast", i), bus.m_WLAST, vt[i].e_last);
            chk($sformatf("v%0d_level", i), fifo_level, vt[i].e_lvl);
            if (vt[i].e_inw) begin
                chk($sformatf("v%0d_wdata", i), bus.m_WDATA, mk(vt[i].e_data));
                chk($sformatf("v%0d_wstrb", i), bus.m_WSTRB, {32{1'b1}});
            end
            if (vt[i].e_awv) begin
                chk("v_awaddr", bus.m_AWADDR, 0);
                chk("v_awlen", bus.m_AWLEN, 15);
                chk("v_awid", bus.m_AWID, 5);
            end
            tick();
        end

        // Address stall: AWREADY low for five cycles.
        aw_q.delete(); w_q.delete();
        bus.m_AWREADY = 0; bus.m_WREADY = 1;
        push(16, 32'h21);
        found = 0;
        for (int i = 0; i < 5 && !found; i++) begin
            @(negedge ACLK); found = bus.m_AWVALID;
            if (!found) tick();
        end
        chk("stall_awvalid_seen", found, 1);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                tick();
                if (k == 5) bus.m_AWREADY = 1;
                @(negedge ACLK);
            end
            chk($sformatf("stall%0d_awvalid", k), bus.m_AWVALID, 1);
            chk($sformatf("stall%0d_awaddr", k), bus.m_AWADDR, 512);
            chk($sformatf("stall%0d_lock", k), axi_wstart_locked, 1);
            chk($sformatf("stall%0d_level", k), fifo_level, 16);
        end
        wait_idle("stall", 60);
        chk_beats("stall_beats", 16, 32'h21);
        chk("stall_aw", aw_at(0), 512);

        // Data stall: WREADY toggles every cycle.
        aw_q.delete(); w_q.delete();
        bus.m_AWREADY = 1; bus.m_WREADY = 0;
        push(16, 32'h41);
        wait_w("tog", found);
        tick();
        for (int i = 0; i < 80 && axi_wstart_locked; i++) begin
            bus.m_WREADY = ~bus.m_WREADY; tick();
        end
        bus.m_WREADY = 0;
        wait_idle("tog", 20);
        chk_beats("tog_beats", 16, 32'h41);
        chk("tog_aw", aw_at(0), 1024);

        // Frame wrap after three bursts, then frame_start in IDLE.
        do_reset();
        bus.m_AWREADY = 1; bus.m_WREADY = 1;
        push(64, 32'h1);
        wait_idle("wrap", 200);
        chk("wrap_aw_n", aw_q.size(), 4);
        chk("wrap_aw0", aw_at(0), 0);
        chk("wrap_aw1", aw_at(1), 512);
        chk("wrap_aw2", aw_at(2), 1024);
        chk("wrap_aw3", aw_at(3), 0);
        chk_beats("wrap_beats", 64, 32'h1);
        aw_q.delete(); w_q.delete();
        push(10, 32'h71);
        @(negedge ACLK);
        chk("fs_level_before", fifo_level, 10);
        tick();
        frame_start = 1; in_valid = 1; in_data = mk(32'hDEAD);
        tick();
        frame_start = 0; in_valid = 0;
        @(negedge ACLK);
        chk("fs_level_after", fifo_level, 0);
        chk("fs_overflow", overflow, 0);
        tick();
        push(16, 32'h81);
        wait_idle("fs", 60);
        chk("fs_aw_n", aw_q.size(), 1);
        chk("fs_aw0", aw_at(0), 0);
        chk_beats("fs_beats", 16, 32'h81);

        // Overflow with everything stalled, restart deferred behind the burst.
        do_reset();
        push(80, 32'h1);
        @(negedge ACLK);
        chk("ovf_level", fifo_level, 64);
        chk("ovf_flag", overflow, 1);
        chk("ovf_awvalid", bus.m_AWVALID, 1);
        tick();
        frame_start = 1; tick(); frame_start = 0;
        bus.m_AWREADY = 1; bus.m_WREADY = 1;
        wait_idle("ovf", 60);
        chk("ovf_level_clr", fifo_level, 0);
        chk("ovf_flag_clr", overflow, 0);
        chk_beats("ovf_beats", 16, 32'h1);
        chk("ovf_aw_n", aw_q.size(), 1);
        aw_q.delete(); w_q.delete();
        push(16, 32'h91);
        wait_idle("ovf2", 60);
        chk("ovf2_aw0", aw_at(0), 0);
        chk_beats("ovf2_beats", 16, 32'h91);

        // frame_start during beat 8 of the burst at 512.
        do_reset();
        bus.m_AWREADY = 1; bus.m_WREADY = 1;
        push(16, 32'h11);
        wait_idle("mid0", 60);
        aw_q.delete(); w_q.delete();
        bus.m_WREADY = 0;
        push(24, 32'h21);
        bus.m_WREADY = 1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge ACLK);
            if (axi_wstart_locked && !bus.m_AWVALID && bus.m_WDATA == mk(32'h28)) begin
                found = 1; frame_start = 1;
            end
            tick();
            frame_start = 0;
        end
        chk("mid_beat8_seen", found, 1);
        wait_idle("mid", 60);
        chk("mid_level", fifo_level, 0);
        chk_beats("mid_beats", 16, 32'h21);
        chk("mid_aw_n", aw_q.size(), 1);
        chk("mid_aw0", aw_at(0), 512);
        aw_q.delete(); w_q.delete();
        push(16, 32'hA1);
        wait_idle("mid2", 60);
        chk("mid2_aw0", aw_at(0), 0);
        chk_beats("mid2_beats", 16, 32'hA1);

        // Reset in the middle of a data phase.
        aw_q.delete(); w_q.delete();
        bus.m_WREADY = 0;
        push(16, 32'hB1);
        wait_w("rmid", found);
        tick();
        bus.m_WREADY = 1;
        repeat (3) tick();
        ARESETn = 1'b0;
        #1;
        chk("rmid_level", fifo_level, 0);
        chk("rmid_lock", axi_wstart_locked, 0);
        chk("rmid_awvalid", bus.m_AWVALID, 0);
        chk("rmid_wlast", bus.m_WLAST, 0);
        tick(); tick();
        ARESETn = 1'b1;
        aw_q.delete(); w_q.delete();
        repeat (5) tick();
        chk("rmid_no_aw", aw_q.size(), 0);
        chk("rmid_no_w", w_q.size(), 0);
        push(16, 32'hC1);
        wait_idle("rmid2", 60);
        chk("rmid2_aw0", aw_at(0), 0);
        chk_beats("rmid2_beats", 16, 32'hC1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
